// File: rtl/param_regfile_pkg.sv
// Shared access-type codes and the per-byte-lane write decoder for param_regfile.
// Codes 10..15 are reserved and decode as read-only.
package regfile_pkg;

    localparam int TYPE_W = 4;

    localparam logic [TYPE_W-1:0] AT_RW    = 4'd0;
    localparam logic [TYPE_W-1:0] AT_RO    = 4'd1;
    localparam logic [TYPE_W-1:0] AT_RC    = 4'd2;
    localparam logic [TYPE_W-1:0] AT_W1C   = 4'd3;
    localparam logic [TYPE_W-1:0] AT_W1S   = 4'd4;
    localparam logic [TYPE_W-1:0] AT_WO    = 4'd5;
    localparam logic [TYPE_W-1:0] AT_WONCE = 4'd6;
    localparam logic [TYPE_W-1:0] AT_W0C   = 4'd7;
    localparam logic [TYPE_W-1:0] AT_W0S   = 4'd8;
    localparam logic [TYPE_W-1:0] AT_W1T   = 4'd9;

    // Reserved codes above W1T fall back to read-only behaviour.
    function automatic logic type_is_ro(input logic [TYPE_W-1:0] t);
        return (t == AT_RO) || (t > AT_W1T);
    endfunction

    function automatic logic [7:0] lane_next(
        input logic [TYPE_W-1:0] t,
        input logic [7:0]        old,
        input logic [7:0]        d
    );
        logic [7:0] res;
        res = old;
        case (t)
            AT_RW, AT_WO, AT_WONCE: res = d;
            AT_W1C:                 res = old & ~d;
            AT_W1S:                 res = old | d;
            AT_W0C:                 res = old & d;
            AT_W0S:                 res = old | ~d;
            AT_W1T:                 res = old ^ d;
            default:                res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/param_regfile_reg_slot.sv
// One register of param_regfile: bus lane update, read-clear, hardware merge
// and the write-once lock flag.
module regfile_reg_slot
    import regfile_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [TYPE_W-1:0]     REG_TYPE    = AT_RW,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH/8-1:0] lane_we,
    input  logic [DATA_WIDTH-1:0]   lane_wdata,
    input  logic                    rd_clear,
    input  logic                    hw_we,
    input  logic [DATA_WIDTH-1:0]   hw_wdata,
    output logic [DATA_WIDTH-1:0]   value
);

    localparam int   LANES      = DATA_WIDTH / 8;
    localparam logic IS_WONCE   = (REG_TYPE == AT_WONCE);
    localparam logic IS_RC      = (REG_TYPE == AT_RC);
    localparam logic IS_HW_OR   = (REG_TYPE == AT_RC) || (REG_TYPE == AT_W1C);
    localparam logic IS_HW_LOAD = type_is_ro(REG_TYPE);

    logic [DATA_WIDTH-1:0] value_q;
    logic [DATA_WIDTH-1:0] bus_val;
    logic [DATA_WIDTH-1:0] post_clr;
    logic [DATA_WIDTH-1:0] next_val;
    logic                  wonce_q;
    logic                  wonce_lock;
    logic                  any_lane;

    assign wonce_lock = IS_WONCE && wonce_q;
    assign any_lane   = |lane_we;
    assign value      = value_q;

    // Precedence builds up in order: bus write, then read-clear, then hardware.
    always_comb begin
        bus_val = value_q;
        for (int l = 0; l < LANES; l++) begin
            if (lane_we[l] && !wonce_lock) begin
                bus_val[l*8 +: 8] = lane_next(REG_TYPE, value_q[l*8 +: 8],
                                              lane_wdata[l*8 +: 8]);
            end
        end

        post_clr = (IS_RC && rd_clear) ? '0 : bus_val;

        next_val = post_clr;
        if (hw_we) begin
            if (IS_HW_LOAD) begin
                next_val = hw_wdata;
            end else if (IS_HW_OR) begin
                next_val = post_clr | hw_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= RESET_VALUE;
            wonce_q <= 1'b0;
        end else begin
            value_q <= next_val;
            if (IS_WONCE && any_lane) begin
                wonce_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_regfile.sv
// Parametrised multi-port register file with per-register access types.
// Optional interrupt output is enabled with `define PARAM_REGFILE_IRQ_EN.
module param_regfile
    import regfile_pkg::*;
#(
    parameter int                              DATA_WIDTH   = 32,
    parameter int                              ADDR_WIDTH   = 8,
    parameter int                              NUM_REGS     = 16,
    parameter int                              WR_PORTS     = 2,
    parameter logic [NUM_REGS*TYPE_W-1:0]      REG_TYPES    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VALUES = '0,
    parameter int                              IRQ_STAT_IDX = 0,
    parameter int                              IRQ_EN_IDX   = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [WR_PORTS-1:0]              wr_en,
    input  logic [WR_PORTS*ADDR_WIDTH-1:0]   wr_addr,
    input  logic [WR_PORTS*DATA_WIDTH-1:0]   wr_data,
    input  logic [WR_PORTS*DATA_WIDTH/8-1:0] wr_be,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic                             rd_err,
    input  logic [NUM_REGS-1:0]              hw_we,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]   hw_wdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_out,
    output logic                             irq
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [LANES-1:0]      lane_we    [NUM_REGS];
    logic [DATA_WIDTH-1:0] lane_wdata [NUM_REGS];
    logic [DATA_WIDTH-1:0] reg_q      [NUM_REGS];
    logic [NUM_REGS-1:0]   rd_hit;
    logic [DATA_WIDTH-1:0] rd_sel;
    logic                  rd_bad;

    // Later ports overwrite earlier ones lane by lane, so the highest index wins.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            lane_we[i]    = '0;
            lane_wdata[i] = '0;
            for (int p = 0; p < WR_PORTS; p++) begin
                if (wr_en[p] && (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i))) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (wr_be[p*LANES + l]) begin
                            lane_we[i][l]          = 1'b1;
                            lane_wdata[i][l*8 +: 8] = wr_data[p*DATA_WIDTH + l*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_hit[i] = rd_en && (rd_addr == ADDR_WIDTH'(i));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_slot
            regfile_reg_slot #(
                .DATA_WIDTH  (DATA_WIDTH),
                .REG_TYPE    (REG_TYPES[g*TYPE_W +: TYPE_W]),
                .RESET_VALUE (RESET_VALUES[g*DATA_WIDTH +: DATA_WIDTH])
            ) u_slot (
                .clk        (clk),
                .rst_n      (rst_n),
                .lane_we    (lane_we[g]),
                .lane_wdata (lane_wdata[g]),
                .rd_clear   (rd_hit[g]),
                .hw_we      (hw_we[g]),
                .hw_wdata   (hw_wdata[g*DATA_WIDTH +: DATA_WIDTH]),
                .value      (reg_q[g])
            );
            assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = reg_q[g];
        end
    endgenerate

    // Write-only registers and out-of-range addresses both return zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((rd_addr == ADDR_WIDTH'(i)) && (REG_TYPES[i*TYPE_W +: TYPE_W] != AT_WO)) begin
                rd_sel = reg_q[i];
            end
        end
    end

    assign rd_bad = (32'(rd_addr) >= NUM_REGS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= rd_en && rd_bad;
            if (rd_en) begin
                rd_data <= rd_bad ? '0 : rd_sel;
            end
        end
    end

`ifdef PARAM_REGFILE_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(reg_q[IRQ_STAT_IDX] & reg_q[IRQ_EN_IDX]);
        end
    end

    assign irq = irq_q;
`else
    localparam int UNUSED_IRQ_IDX = IRQ_STAT_IDX + IRQ_EN_IDX;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_param_regfile.sv
// Directed, table-driven bench for param_regfile plus hand sequences for
// read-clear with hardware set, write-once across reset, and irq timing.
module tb_param_regfile;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 10;
    localparam int WP = 2;

    // reg: 9 RW, 8 RO, 7 WO, 6 WONCE, 5 RC, 4 W0S, 3 W1T, 2 W1C, 1 RW, 0 RW
    localparam logic [NR*4-1:0] TYPES = 40'h01_5628_9300;
    localparam logic [NR*DW-1:0] RSTV = {32'h0, 32'h12345678, 32'h0, 32'h0,
                                         32'h5, 32'h0, 32'hF0, 32'hFF,
                                         32'hFFFFFFFF, 32'h1};

    logic                   clk;
    logic                   rst_n;
    logic [WP-1:0]          wr_en;
    logic [WP*AW-1:0]       wr_addr;
    logic [WP*DW-1:0]       wr_data;
    logic [WP*DW/8-1:0]     wr_be;
    logic                   rd_en;
    logic [AW-1:0]          rd_addr;
    logic [DW-1:0]          rd_data;
    logic                   rd_valid;
    logic                   rd_err;
    logic [NR-1:0]          hw_we;
    logic [NR*DW-1:0]       hw_wdata;
    logic [NR*DW-1:0]       reg_out;
    logic                   irq;

    int checks = 0;
    int errors = 0;

    param_regfile #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .NUM_REGS     (NR),
        .WR_PORTS     (WP),
        .REG_TYPES    (TYPES),
        .RESET_VALUES (RSTV),
        .IRQ_STAT_IDX (0),
        .IRQ_EN_IDX   (9)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_err   (rd_err),
        .hw_we    (hw_we),
        .hw_wdata (hw_wdata),
        .reg_out  (reg_out),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        p0_en;
        logic [7:0]  p0_addr;
        logic [31:0] p0_data;
        logic [3:0]  p0_be;
        logic        p1_en;
        logic [7:0]  p1_addr;
        logic [31:0] p1_data;
        logic [3:0]  p1_be;
        logic        r_en;
        logic [7:0]  r_addr;
        int          chk_idx;
        logic [31:0] exp_reg;
        logic        exp_valid;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_be    = '0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        hw_we    = '0;
        hw_wdata = '0;
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] regv(input int idx);
        return reg_out[idx*DW +: DW];
    endfunction

    task automatic writePort(input int p, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en[p]              = 1'b1;
        wr_addr[p*AW +: AW]   = a;
        wr_data[p*DW +: DW]   = d;
        wr_be[p*4 +: 4]       = be;
    endtask

    task automatic applyStimulus(input vec_t v);
        idle();
        if (v.p0_en) writePort(0, v.p0_addr, v.p0_data, v.p0_be);
        if (v.p1_en) writePort(1, v.p1_addr, v.p1_data, v.p1_be);
        rd_en   = v.r_en;
        rd_addr = v.r_addr;
        tick();
        idle();
    endtask

    task automatic checkOutput(input vec_t v);
        checkValue({v.name, ".reg"}, regv(v.chk_idx), v.exp_reg);
        checkValue({v.name, ".rd_data"}, rd_data, v.exp_rd);
        checkValue({v.name, ".rd_valid"}, 32'(rd_valid), 32'(v.exp_valid));
        if (v.exp_valid) checkValue({v.name, ".rd_err"}, 32'(rd_err), 32'(v.exp_err));
    endtask

    function automatic vec_t mk(input string n,
                                input logic e0, input logic [7:0] a0, input logic [31:0] d0, input logic [3:0] b0,
                                input logic e1, input logic [7:0] a1, input logic [31:0] d1, input logic [3:0] b1,
                                input logic re, input logic [7:0] ra, input int ci, input logic [31:0] er,
                                input logic ev, input logic [31:0] erd, input logic ee);
        vec_t v;
        v.name = n; v.p0_en = e0; v.p0_addr = a0; v.p0_data = d0; v.p0_be = b0;
        v.p1_en = e1; v.p1_addr = a1; v.p1_data = d1; v.p1_be = b1;
        v.r_en = re; v.r_addr = ra; v.chk_idx = ci; v.exp_reg = er;
        v.exp_valid = ev; v.exp_rd = erd; v.exp_err = ee;
        return v;
    endfunction

    logic exp_irq;

    initial begin
`ifdef PARAM_REGFILE_IRQ_EN
        exp_irq = 1'b1;
`else
        exp_irq = 1'b0;
`endif
        //            name        p0: en addr data          be     p1: en addr data          be     rd en addr  chk exp_reg        valid exp_rd        err
        vecs.push_back(mk("rd_r1",    0, 0, 32'h0,        4'h0,  0, 0, 32'h0,        4'h0,  1, 8'd1,  1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0));
        vecs.push_back(mk("prio",     1, 0, 32'h11223344, 4'hF,  1, 0, 32'hAABBCCDD, 4'h3,  0, 8'd0,  0, 32'h1122CCDD, 0, 32'hFFFFFFFF, 0));
        vecs.push_back(mk("w1c",      1, 2, 32'h0000000F, 4'hF,  0, 0, 32'h0,        4'h0,  0, 8'd0,  2, 32'h000000F0, 0, 32'hFFFFFFFF, 0));
        vecs.push_back(mk("w1t",      1, 3, 32'h000000FF, 4'hF,  0, 0, 32'h0,        4'h0,  0, 8'd0,  3, 32'h0000000F, 0, 32'hFFFFFFFF, 0));
        vecs.push_back(mk("w0s",      1, 4, 32'hFFFFFFFE, 4'hF,  0, 0, 32'h0,        4'h0,  0, 8'd0,  4, 32'h00000001, 0, 32'hFFFFFFFF, 0));
        vecs.push_back(mk("nobypass", 1, 0, 32'hDEADBEEF, 4'hF,  0, 0, 32'h0,        4'h0,  1, 8'd0,  0, 32'hDEADBEEF, 1, 32'h1122CCDD, 0));
        vecs.push_back(mk("rc_noen",  0, 0, 32'h0,        4'h0,  0, 0, 32'h0,        4'h0,  0, 8'd5,  5, 32'h00000005, 0, 32'h1122CCDD, 0));
        vecs.push_back(mk("rc_read",  0, 0, 32'h0,        4'h0,  0, 0, 32'h0,        4'h0,  1, 8'd5,  5, 32'h00000000, 1, 32'h00000005, 0));
        vecs.push_back(mk("rc_wr_ro", 0, 0, 32'h0,        4'h0,  1, 5, 32'h0000FFFF, 4'hF,  1, 8'd8,  5, 32'h00000000, 1, 32'h12345678, 0));
        vecs.push_back(mk("wo_read",  1, 7, 32'hCAFEF00D, 4'hF,  0, 0, 32'h0,        4'h0,  1, 8'd7,  7, 32'hCAFEF00D, 1, 32'h00000000, 0));
        vecs.push_back(mk("bad_addr", 1, 10, 32'h0,       4'hF,  0, 0, 32'h0,        4'h0,  1, 8'd10, 0, 32'hDEADBEEF, 1, 32'h00000000, 1));
        vecs.push_back(mk("ro_wr",    1, 8, 32'h0,        4'hF,  0, 0, 32'h0,        4'h0,  0, 8'd0,  8, 32'h12345678, 0, 32'h00000000, 0));
        vecs.push_back(mk("be_zero",  0, 0, 32'h0,        4'h0,  1, 2, 32'hFFFFFFFF, 4'h0,  0, 8'd0,  2, 32'h000000F0, 0, 32'h00000000, 0));
        vecs.push_back(mk("w1t_lanes",1, 3, 32'h0000FF00, 4'h2,  1, 3, 32'hFFFF0000, 4'hC,  1, 8'd1,  3, 32'hFFFFFF0F, 1, 32'hFFFFFFFF, 0));

        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < NR; i++) begin
            checkValue($sformatf("reset.reg%0d", i), regv(i), RSTV[i*DW +: DW]);
        end
        checkValue("reset.rd_data", rd_data, 32'h0);
        checkValue("reset.rd_valid", 32'(rd_valid), 32'h0);
        checkValue("reset.rd_err", 32'(rd_err), 32'h0);
        checkValue("reset.irq", 32'(irq), 32'h0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k]);
            checkOutput(vecs[k]);
        end

        // Hardware updates: RC ORs, RO loads, RW ignores.
        hw_we[5] = 1'b1; hw_wdata[5*DW +: DW] = 32'h3;
        hw_we[8] = 1'b1; hw_wdata[8*DW +: DW] = 32'h0000BEEF;
        hw_we[0] = 1'b1; hw_wdata[0*DW +: DW] = 32'h0000FFFF;
        tick();
        idle();
        checkValue("hw.rc_or", regv(5), 32'h3);
        checkValue("hw.ro_load", regv(8), 32'h0000BEEF);
        checkValue("hw.rw_ignored", regv(0), 32'hDEADBEEF);

        // Read-clear and hardware set in the same cycle: set wins.
        rd_en = 1'b1; rd_addr = 8'd5;
        hw_we[5] = 1'b1; hw_wdata[5*DW +: DW] = 32'h8;
        tick();
        idle();
        checkValue("rchw.rd_data", rd_data, 32'h3);
        checkValue("rchw.reg", regv(5), 32'h8);
        rd_en = 1'b1; rd_addr = 8'd5;
        tick();
        idle();
        checkValue("rc2.rd_data", rd_data, 32'h8);
        checkValue("rc2.reg", regv(5), 32'h0);

        // Write-once register locks after the first write until reset.
        writePort(0, 8'd6, 32'hA5, 4'hF);
        tick();
        idle();
        checkValue("wonce.first", regv(6), 32'hA5);
        writePort(1, 8'd6, 32'h5A, 4'hF);
        tick();
        idle();
        checkValue("wonce.locked", regv(6), 32'hA5);

        // Reset overrides a concurrent write and read.
        rst_n = 1'b0;
        writePort(0, 8'd0, 32'h77, 4'hF);
        rd_en = 1'b1; rd_addr = 8'd1;
        tick();
        idle();
        rst_n = 1'b1;
        checkValue("midrst.reg0", regv(0), 32'h1);
        checkValue("midrst.reg6", regv(6), 32'h0);
        checkValue("midrst.rd_valid", 32'(rd_valid), 32'h0);
        checkValue("midrst.rd_data", rd_data, 32'h0);
        writePort(0, 8'd6, 32'h5A, 4'hF);
        tick();
        idle();
        checkValue("wonce.after_rst", regv(6), 32'h5A);

        // irq: stat and enable written in cycle t, irq expected at t+2.
        writePort(0, 8'd0, 32'h4, 4'hF);
        writePort(1, 8'd9, 32'h4, 4'hF);
        tick();
        idle();
        checkValue("irq.t1_reg0", regv(0), 32'h4);
        checkValue("irq.t1", 32'(irq), 32'h0);
        tick();
        checkValue("irq.t2", 32'(irq), 32'(exp_irq));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
